// File: rtl/jtag_mem_access_reg.sv
// JTAG memory-access data register: shifts in {op, addr, wdata}, issues one bus access per
// Update-DR, and captures read data plus sticky status. Optional macro: JTAG_MEM_TIMEOUT_EN.
module jtag_mem_access_reg #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  tck_i,
  input  logic                  rst_ni,
  input  logic                  td_i,
  output logic                  td_o,
  input  logic                  sel_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  err_i
);

  // state   | meaning
  // IDLE    | no access in flight, commands accepted
  // REQ     | req_o held with stable address/data until gnt_i
  // WAIT    | granted, waiting for rvalid_i (or timeout when enabled)
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10,
                            OP_READ_NEXT = 2'b11} op_e;

  localparam int unsigned L = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

  state_e                state_q, state_d;
  logic [L-1:0]          dr_q, dr_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;

`ifdef JTAG_MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

  op_e                   op;
  logic                  busy;
  logic                  cmd_vld;
  logic [ADDR_WIDTH-1:0] dr_addr;
  logic [DATA_WIDTH-1:0] dr_wdata;

  assign op       = op_e'(dr_q[L-1 -: 2]);
  assign dr_addr  = dr_q[DATA_WIDTH +: ADDR_WIDTH];
  assign dr_wdata = dr_q[DATA_WIDTH-1:0];
  assign busy     = (state_q != ST_IDLE);
  assign cmd_vld  = sel_i & update_dr_i & (op != OP_NOP);

  always_comb begin
    state_d     = state_q;
    dr_d        = dr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    next_addr_d = next_addr_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
`ifdef JTAG_MEM_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    // Capture clears the sticky bits first so a set event below on the same edge wins.
    if (sel_i && capture_dr_i) begin
      dr_d                   = '0;
      dr_d[DATA_WIDTH-1:0]   = rdata_q;
      dr_d[DATA_WIDTH]       = busy;
      dr_d[DATA_WIDTH+1]     = err_q;
      dr_d[DATA_WIDTH+2]     = ovr_q;
      err_d                  = 1'b0;
      ovr_d                  = 1'b0;
    end else if (sel_i && shift_dr_i) begin
      dr_d = {td_i, dr_q[L-1:1]};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = (op == OP_WRITE);
          addr_d  = (op == OP_READ_NEXT) ? next_addr_q : dr_addr;
          wdata_d = dr_wdata;
        end
      end
      ST_REQ: begin
        if (cmd_vld) ovr_d = 1'b1;
        if (gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
`ifdef JTAG_MEM_TIMEOUT_EN
          to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ST_WAIT: begin
        if (cmd_vld) ovr_d = 1'b1;
        if (rvalid_i) begin
          if (!we_q) rdata_d = rdata_i;
          if (err_i) err_d = 1'b1;
          next_addr_d = addr_q + ADDR_STEP;
          state_d     = ST_IDLE;
        end
`ifdef JTAG_MEM_TIMEOUT_EN
        else if (to_cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      dr_q        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      next_addr_q <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef JTAG_MEM_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dr_q        <= dr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
`ifdef JTAG_MEM_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign td_o    = dr_q[0];
  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule
